// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, functs, FSM states and funct legality for multicycle_cpu_p.
// MULT_EN makes funct 0x18 (mul) a legal R-type operation.
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3f;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_MUL   = 6'h18;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_REGRD, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  function automatic logic fn_legal(input logic [5:0] fn);
`ifdef MULT_EN
    return fn inside {FN_ADDU, FN_SUBU, FN_SLT, FN_MUL};
`else
    return fn inside {FN_ADDU, FN_SUBU, FN_SLT};
`endif
  endfunction
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU (addu/subu/slt, mul when MULT_EN) with zero flag.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  input  logic [5:0]        i_funct,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);
  logic [DATA_W-1:0] w_mul;
`ifdef MULT_EN
  assign w_mul = i_op1 * i_op2;
`else
  assign w_mul = '0;
`endif
  always_comb begin
    o_result = i_funct == FN_ADDU ? i_op1 + i_op2 :
               i_funct == FN_SUBU ? i_op1 - i_op2 :
               i_funct == FN_SLT  ? {{(DATA_W-1){1'b0}}, $signed(i_op1) < $signed(i_op2)} :
               i_funct == FN_MUL  ? w_mul : '0;
    o_zero = o_result == '0;
  end
endmodule

// File: rtl/multicycle_cpu_p.sv
// multicycle_cpu_p: six-state multi-cycle MIPS-subset core with load port and debug read.
// Optional MULT_EN adds the R-type mul instruction.
module multicycle_cpu_p
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NREGS      = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 8,
  parameter int PC_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     ld_we,
  input  logic                     ld_sel,
  input  logic [PC_W-1:0]          ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [PC_W-1:0]          pc,
  output logic [15:0]              retired,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);
  localparam int AW = $clog2(NREGS);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  state_t r_state, w_next;
  logic [31:0] r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] r_rf [NREGS];
  logic [31:0] r_instr;
  logic [DATA_W-1:0] r_imm, r_op1, r_op2, r_alu, r_mem;
  logic [PC_W-1:0] r_pc;
  logic [15:0] r_retired;
  logic r_err, r_done;
  logic [5:0] w_op, w_fn, w_alu_fn;
  logic [AW-1:0] w_rs, w_rt, w_rd, w_wa;
  logic [DATA_W-1:0] w_alu_b, w_alu, w_wd;
  logic [PC_W-1:0] w_npc;
  logic w_zero, w_rtype, w_brn, w_legal, w_taken, w_addr_ok, w_end, w_wen;
  assign w_op = r_instr[31:26];
  assign w_fn = r_instr[5:0];
  assign w_rs = r_instr[21 +: AW];
  assign w_rt = r_instr[16 +: AW];
  assign w_rd = r_instr[11 +: AW];
  assign w_rtype = w_op == OP_RTYPE;
  assign w_brn = w_op == OP_BEQ || w_op == OP_BNE;
  assign w_legal = w_rtype ? fn_legal(w_fn) :
                   w_op inside {OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT};
  // Branches compare via subtraction; loads/stores/addiu add the immediate.
  assign w_alu_fn = w_rtype ? w_fn : w_brn ? FN_SUBU : FN_ADDU;
  assign w_alu_b = (w_rtype || w_brn) ? r_op2 : r_imm;
  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op1(r_op1), .i_op2(w_alu_b), .i_funct(w_alu_fn), .o_result(w_alu), .o_zero(w_zero)
  );
  assign w_taken = (w_op == OP_BEQ && w_zero) || (w_op == OP_BNE && !w_zero);
  assign w_npc = w_op == OP_J    ? r_instr[PC_W-1:0] :
                 w_op == OP_HALT ? r_pc :
                 w_taken         ? r_pc + PC_W'($signed(r_instr[15:0])) : r_pc + PC_W'(1);
  assign w_addr_ok = 32'(r_alu) < DMEM_DEPTH;
  assign w_end = w_op == OP_HALT || 32'(r_pc) >= IMEM_DEPTH;
  assign w_wa = w_rtype ? w_rd : w_rt;
  assign w_wd = w_op == OP_LW ? r_mem : r_alu;
  assign w_wen = w_wa != '0 && ((w_rtype && w_legal) || w_op == OP_ADDIU || w_op == OP_LW);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: w_next = start ? S_FETCH : r_state;
      S_FETCH:        w_next = S_DECODE;
      S_DECODE:       w_next = S_REGRD;
      S_REGRD:        w_next = S_EXEC;
      S_EXEC:         w_next = S_MEM;
      S_MEM:          w_next = S_WB;
      default:        w_next = w_end ? S_HALT : S_FETCH;
    endcase
  end
  always_comb busy = !(r_state == S_IDLE || r_state == S_HALT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
      r_retired <= '0;
      r_err <= 1'b0;
      r_done <= 1'b0;
      r_instr <= '0;
      r_imm <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
      r_alu <= '0;
      r_mem <= '0;
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else begin
      r_done <= r_state == S_WB && w_end;
      case (r_state)
        S_IDLE, S_HALT: if (start) begin
          r_pc <= '0;
          r_retired <= '0;
          r_err <= 1'b0;
        end
        S_FETCH:  r_instr <= r_imem[r_pc[IW-1:0]];
        S_DECODE: r_imm <= DATA_W'($signed(r_instr[15:0]));
        S_REGRD: begin
          r_op1 <= r_rf[w_rs];
          r_op2 <= r_rf[w_rt];
        end
        S_EXEC: begin
          r_alu <= w_alu;
          r_pc <= w_npc;
          if (!w_legal) r_err <= 1'b1;
        end
        S_MEM: begin
          r_mem <= (w_op == OP_LW && w_addr_ok) ? r_dmem[r_alu[DW-1:0]] : '0;
          if ((w_op == OP_LW || w_op == OP_SW) && !w_addr_ok) r_err <= 1'b1;
        end
        default: begin
          r_retired <= r_retired + 16'd1;
          if (w_wen) r_rf[w_wa] <= w_wd;
        end
      endcase
    end
  end
  // Memories survive reset; load port only acts while the core is idle or halted.
  always_ff @(posedge clk) begin
    if (!busy && ld_we && !ld_sel && 32'(ld_addr) < IMEM_DEPTH) r_imem[ld_addr[IW-1:0]] <= ld_data;
    if (!busy && ld_we && ld_sel && 32'(ld_addr) < DMEM_DEPTH) r_dmem[ld_addr[DW-1:0]] <= ld_data[DATA_W-1:0];
    if (r_state == S_MEM && w_op == OP_SW && w_addr_ok) r_dmem[r_alu[DW-1:0]] <= r_op2;
  end
  assign done = r_done;
  assign err = r_err;
  assign pc = r_pc;
  assign retired = r_retired;
  assign dbg_data = r_rf[dbg_addr];
endmodule

// File: doc/multicycle_cpu_p.md
Name: multicycle_cpu_p

Overview:
- Parametrised multi-cycle MIPS-subset processor. Next generation of the team's 8-bit six-state lab core.
- Generalised data width, register count and memory depths.
- Adds:
  - asynchronous reset;
  - a program/data load port;
  - a start/done handshake;
  - store, subtract, jump and halt instructions;
  - an error flag and a debug register-read port.
- Sits under the lab testbench; instruction and data memories are internal arrays.

Parameters:
- DATA_W, 8, register/data-memory word width (4..32).
- NREGS, 32, register file entries (power of two, 2..32; r0 reads 0, writes ignored).
- IMEM_DEPTH, 16, instruction words (32-bit each).
- DMEM_DEPTH, 8, data-memory words of DATA_W.
- PC_W, 8, program-counter width (must satisfy 2^PC_W >= IMEM_DEPTH).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, begin execution from pc=0; sampled in IDLE/HALT only.
- ld_we, input, 1, load-port write strobe; honoured in IDLE/HALT only.
- ld_sel, input, 1, 0 = instruction memory, 1 = data memory.
- ld_addr, input, PC_W, load word address; out-of-range writes dropped.
- ld_data, input, 32, load data; data memory takes [DATA_W-1:0].
- busy, output, 1, high from FETCH through WB.
- done, output, 1, one-cycle pulse on entry to HALT.
- err, output, 1, sticky illegal-opcode/address flag; cleared by start or rst.
- pc, output, PC_W, current program counter.
- retired, output, 16, instructions completed since start; wraps at 65535.
- dbg_addr, input, clog2(NREGS), debug register select.
- dbg_data, output, DATA_W, combinational register_file[dbg_addr].

Behaviour:
- rst (async, any state, including mid-instruction):
  - state=IDLE; pc=0; busy=0, done=0, err=0, retired=0;
  - all registers cleared;
  - memories NOT cleared.
- States and transitions:
  - IDLE --start--> FETCH.
  - FETCH: instr <= imem[pc] --> DECODE.
  - DECODE: split fields, imm = sign-extend(instr[15:0]) truncated to DATA_W --> REGRD.
  - REGRD: op1 = rf[rs], op2 = rf[rt] --> EXEC.
  - EXEC: ALU operation, branch resolution, pc update --> MEM.
  - MEM: lw read / sw write --> WB.
  - WB: register write, retired += 1; --> HALT if halt or pc >= IMEM_DEPTH, else FETCH.
  - HALT --start--> FETCH (pc=0, retired=0, err=0).
- Latency: exactly 6 cycles per instruction (FETCH..WB), all opcodes.
- Instruction set (all arithmetic mod 2^DATA_W):
  - R-type, opcode 0:
    - funct 0x21 addu: rd = rs + rt.
    - funct 0x23 subu: rd = rs - rt.
    - funct 0x2a slt: rd = 1 if signed rs < signed rt, else 0.
  - 0x09 addiu: rt = rs + imm.
  - 0x23 lw: rt = dmem[rs + imm].
  - 0x2b sw: dmem[rs + imm] = rt.
  - 0x04 beq / 0x05 bne:
    - taken: pc = pc + imm (relative to the branch itself; matches existing program encoding);
    - not taken: pc + 1.
  - 0x02 j: pc = instr[PC_W-1:0].
  - 0x3f halt: pc unchanged, enter HALT after WB.
  - All other instructions: pc + 1.
- Error conditions (each sets err):
  - Unknown opcode or R-type funct: treated as nop.
  - lw/sw address >= DMEM_DEPTH: lw returns 0, sw dropped.
- Boundaries:
  - Writes to r0 discarded.
  - A branch/jump to pc >= IMEM_DEPTH halts at WB; err stays 0.
  - pc wraps modulo 2^PC_W before the halt check.
  - start while busy is ignored.
  - ld_we while busy is ignored.
  - ld_we and start in the same cycle: the load write completes and execution starts.

Optional Feature:
- Macro: MULT_EN.
- Defined: R-type funct 0x18 mul, rd = low DATA_W bits of (rs * rt), unsigned; same 6-cycle latency.
- Undefined: funct 0x18 is illegal (nop + err).

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT);
  - funct constants (FN_ADDU, FN_SUBU, FN_SLT, FN_MUL);
  - state enum typedef.
- One sub-module: cpu_alu (combinational; op1, op2, funct -> result, zero flag), parametrised by DATA_W.

Test Plan:
- Load dmem {0xEC, 0x0A, 0x02}, 11-instruction sum-loop program + halt; start -> done pulse; dbg r4 = 0xA6 (-90), r5 = 0x0A, err = 0, retired = 50.
- sw/lw round trip: addiu r1 = 0x55, sw r1 -> dmem[3], lw r2 <- dmem[3] -> r2 = 0x55; separate lw from dmem[DMEM_DEPTH] -> 0, err = 1.
- addiu r0, r0, 7 then addu r3 = r0 + r0 -> r0 reads 0, r3 = 0; subu 0x03 - 0x05 -> 0xFE.
- Assert rst during MEM of a sw -> busy = 0, pc = 0, registers 0 within the same cycle; a restart reproduces the same results.
- Instance DATA_W = 16, NREGS = 8: addiu r1 = -1 -> 0xFFFF; slt r2 = r1 < r0 -> 1; j 0x0F with IMEM_DEPTH = 16 -> halt at pc 15 opcode.
- MULT_EN defined: 0x0C * 0x0B -> 0x84. Undefined: same instruction -> err = 1, rd unchanged.
